// File: rtl/shunt_hs_rx_deframer_if.sv
// Byte-stream input, header report and element output of the SHUNT receive deframer.
// The slave modport is the deframer's view; the master modport is the transport and consumer side.
interface shunt_hs_rx_deframer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        hdr_valid;
    logic [63:0] hdr_trnx_type;
    logic [63:0] hdr_trnx_id;
    logic [63:0] hdr_data_type;
    logic [31:0] hdr_n_payloads;
    logic        elem_valid;
    logic        elem_ready;
    logic [63:0] elem_data;
    logic        elem_last;
    logic        err;

    modport slave (
        input  in_valid, in_data, elem_ready,
        output in_ready, hdr_valid, hdr_trnx_type, hdr_trnx_id, hdr_data_type,
               hdr_n_payloads, elem_valid, elem_data, elem_last, err
    );

    modport master (
        output in_valid, in_data, elem_ready,
        input  in_ready, hdr_valid, hdr_trnx_type, hdr_trnx_id, hdr_data_type,
               hdr_n_payloads, elem_valid, elem_data, elem_last, err
    );
endinterface

// File: rtl/shunt_hs_rx_deframer.sv
// SHUNT receive deframer: rebuilds the 28-byte cs_header from a byte stream, then
// unpacks n_payloads little-endian elements of 1, 4 or 8 bytes onto a valid/ready port.
//
//  state | meaning
//  S_HDR | collecting the 28 header bytes
//  S_DEC | one cycle, hdr_valid high, payload count loaded
//  S_PAY | collecting the bytes of one element
//  S_OUT | element presented, waiting for elem_ready
module shunt_hs_rx_deframer #(
    parameter logic [63:0] DT_BYTE      = 64'h1,
    parameter logic [63:0] DT_INT       = 64'h2,
    parameter logic [63:0] DT_REAL      = 64'h3,
    parameter int unsigned MAX_PAYLOADS = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    shunt_hs_rx_deframer_if.slave         bus
);

    typedef enum logic [1:0] {S_HDR, S_DEC, S_PAY, S_OUT} state_t;

    state_t        state_q;
    logic [215:0]  hdr_sr_q;
    logic [4:0]    hcnt_q;
    logic [2:0]    ecnt_q;
    logic [3:0]    esize_q;
    logic [31:0]   pcnt_q;
    logic          in_ready_q;
    logic          hdr_valid_q;
    logic [63:0]   hdr_type_q;
    logic [63:0]   hdr_id_q;
    logic [63:0]   hdr_dt_q;
    logic [31:0]   hdr_n_q;
    logic          elem_valid_q;
    logic [63:0]   elem_data_q;
    logic          elem_last_q;
    logic          err_q;

    logic          in_xfer;
    logic [223:0]  hdr_d;
    logic [3:0]    esize_d;
    logic          code_ok_d;
    logic          err_d;

    assign in_xfer = bus.in_valid && in_ready_q;
    // The 28th byte completes the header in the same cycle it is accepted.
    assign hdr_d   = {bus.in_data, hdr_sr_q};

    always_comb begin
        esize_d   = 4'd1;
        code_ok_d = 1'b1;
        if (hdr_d[191:128] == DT_BYTE) begin
            esize_d = 4'd1;
        end else if (hdr_d[191:128] == DT_INT) begin
            esize_d = 4'd4;
        end else if (hdr_d[191:128] == DT_REAL) begin
            esize_d = 4'd8;
        end else begin
            code_ok_d = 1'b0;
        end
        err_d = !code_ok_d || (hdr_d[223:192] > 32'(MAX_PAYLOADS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_HDR;
            hdr_sr_q     <= '0;
            hcnt_q       <= '0;
            ecnt_q       <= '0;
            esize_q      <= 4'd1;
            pcnt_q       <= '0;
            in_ready_q   <= 1'b0;
            hdr_valid_q  <= 1'b0;
            hdr_type_q   <= '0;
            hdr_id_q     <= '0;
            hdr_dt_q     <= '0;
            hdr_n_q      <= '0;
            elem_valid_q <= 1'b0;
            elem_data_q  <= '0;
            elem_last_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_HDR: begin
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        hdr_sr_q <= hdr_d[223:8];
                        if (hcnt_q == 5'd27) begin
                            hcnt_q      <= '0;
                            state_q     <= S_DEC;
                            in_ready_q  <= 1'b0;
                            hdr_valid_q <= 1'b1;
                            hdr_type_q  <= hdr_d[63:0];
                            hdr_id_q    <= hdr_d[127:64];
                            hdr_dt_q    <= hdr_d[191:128];
                            hdr_n_q     <= hdr_d[223:192];
                            esize_q     <= esize_d;
                            err_q       <= err_d;
                        end else begin
                            hcnt_q <= hcnt_q + 5'd1;
                        end
                    end
                end
                S_DEC: begin
                    hdr_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    if (hdr_n_q == 32'd0) begin
                        state_q <= S_HDR;
                        err_q   <= 1'b0;
                    end else begin
                        pcnt_q  <= hdr_n_q;
                        ecnt_q  <= '0;
                        state_q <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (in_xfer) begin
                        if (ecnt_q == 3'd0) begin
                            elem_data_q <= {56'd0, bus.in_data};
                        end else begin
                            elem_data_q[{ecnt_q, 3'b000} +: 8] <= bus.in_data;
                        end
                        if ({1'b0, ecnt_q} == esize_q - 4'd1) begin
                            ecnt_q       <= '0;
                            state_q      <= S_OUT;
                            in_ready_q   <= 1'b0;
                            elem_valid_q <= 1'b1;
                            elem_last_q  <= (pcnt_q == 32'd1);
                            pcnt_q       <= pcnt_q - 32'd1;
                        end else begin
                            ecnt_q <= ecnt_q + 3'd1;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.elem_ready) begin
                        elem_valid_q <= 1'b0;
                        in_ready_q   <= 1'b1;
                        if (pcnt_q == 32'd0) begin
                            state_q     <= S_HDR;
                            elem_last_q <= 1'b0;
                            err_q       <= 1'b0;
                        end else begin
                            state_q <= S_PAY;
                        end
                    end
                end
                default: state_q <= S_HDR;
            endcase
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.hdr_valid      = hdr_valid_q;
    assign bus.hdr_trnx_type  = hdr_type_q;
    assign bus.hdr_trnx_id    = hdr_id_q;
    assign bus.hdr_data_type  = hdr_dt_q;
    assign bus.hdr_n_payloads = hdr_n_q;
    assign bus.elem_valid     = elem_valid_q;
    assign bus.elem_data      = elem_data_q;
    assign bus.elem_last      = elem_last_q;
    assign bus.err            = err_q;

endmodule

// File: tb/tb_shunt_hs_rx_deframer.sv
// Bench for shunt_hs_rx_deframer: a transaction-level model turns each header/payload
// description into expected headers and elements, and a per-cycle monitor compares.
module tb_shunt_hs_rx_deframer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shunt_hs_rx_deframer_if ifc();
    shunt_hs_rx_deframer dut (.clk(clk), .rst(rst), .bus(ifc));

    typedef logic [7:0] bq_t[$];
    typedef struct {logic [63:0] t; logic [63:0] id; logic [63:0] dt; logic [31:0] n; logic err;} hdr_t;
    typedef struct {logic [63:0] d; logic last;} elem_t;

    hdr_t        hq[$];
    elem_t       eq[$];
    logic [7:0]  sb[$];
    bit          sf[$];

    int checks = 0, errors = 0;
    int cyc = 0, exp_hdr_cyc = -1, xfer_count = 0, hdr_seen = 0, stall_seen = 0;
    int stall_at = -1, stall_left = 0, gap_max = 0;
    bit busy = 0, cur_err = 0, hdr_last_flag = 0, prev_valid = 0, prev_acc = 0;
    logic [63:0] prev_data = '0, got_data = '0;
    logic        prev_last = 1'b0, got_last = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: header fields LSB-first, element size from data_type, little-endian assembly.
    function automatic void add_txn(input logic [63:0] t, input logic [63:0] id,
                                    input logic [63:0] dt, input logic [31:0] n, input bq_t pay);
        hdr_t h;
        elem_t e;
        int es;
        logic [223:0] hb;
        hb = {n, dt, id, t};
        for (int k = 0; k < 28; k++) begin
            sb.push_back(hb[8*k +: 8]);
            sf.push_back(k == 27);
        end
        es = (dt == 64'h1) ? 1 : (dt == 64'h2) ? 4 : (dt == 64'h3) ? 8 : 1;
        h.t = t; h.id = id; h.dt = dt; h.n = n;
        h.err = !(dt == 64'h1 || dt == 64'h2 || dt == 64'h3) || (n > 32'd4096);
        hq.push_back(h);
        for (int i = 0; i < int'(n); i++) begin
            e.d = '0;
            for (int k = 0; k < es; k++) begin
                e.d = e.d | (64'(pay[i*es + k]) << (8*k));
                sb.push_back(pay[i*es + k]);
                sf.push_back(1'b0);
            end
            e.last = (i == int'(n) - 1);
            eq.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        hdr_t  h;
        elem_t e;
        cyc++;
        if (rst) begin
            busy = 0; prev_valid = 0; prev_acc = 0; exp_hdr_cyc = -1;
        end else if (cyc > 1) begin
            chk("hdr_valid_timing", {63'd0, ifc.hdr_valid}, {63'd0, (cyc == exp_hdr_cyc)});
            if (ifc.hdr_valid) begin
                hdr_seen++;
                if (hq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL hdr_unexpected got=hdr_valid exp=none");
                end else begin
                    h = hq.pop_front();
                    chk("hdr_type", ifc.hdr_trnx_type, h.t);
                    chk("hdr_id", ifc.hdr_trnx_id, h.id);
                    chk("hdr_dt", ifc.hdr_data_type, h.dt);
                    chk("hdr_n", {32'd0, ifc.hdr_n_payloads}, {32'd0, h.n});
                    cur_err = h.err;
                    busy = (h.n != 0);
                end
            end
            chk("err", {63'd0, ifc.err}, {63'd0, (busy || ifc.hdr_valid) ? cur_err : 1'b0});
            if (ifc.elem_valid) begin
                chk("in_ready_while_elem", {63'd0, ifc.in_ready}, 64'd0);
                if (prev_valid && !prev_acc) begin
                    chk("elem_data_stable", ifc.elem_data, prev_data);
                    chk("elem_last_stable", {63'd0, ifc.elem_last}, {63'd0, prev_last});
                end
                if (!ifc.elem_ready) stall_seen++;
            end
            if (ifc.elem_valid && ifc.elem_ready) begin
                xfer_count++;
                if (eq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL elem_unexpected got=%h exp=none", ifc.elem_data);
                end else begin
                    e = eq.pop_front();
                    chk("elem_data", ifc.elem_data, e.d);
                    chk("elem_last", {63'd0, ifc.elem_last}, {63'd0, e.last});
                    got_data = ifc.elem_data;
                    got_last = ifc.elem_last;
                    if (e.last) busy = 0;
                end
            end
            prev_valid = ifc.elem_valid;
            prev_acc   = ifc.elem_valid && ifc.elem_ready;
            prev_data  = ifc.elem_data;
            prev_last  = ifc.elem_last;
            if (ifc.in_valid && ifc.in_ready && hdr_last_flag) exp_hdr_cyc = cyc + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (stall_left > 0 && ifc.elem_valid && xfer_count == stall_at) begin
            ifc.elem_ready = 1'b0;
            stall_left--;
        end else begin
            ifc.elem_ready = 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit last_hdr);
        int t;
        t = 0;
        ifc.in_valid  = 1'b1;
        ifc.in_data   = b;
        hdr_last_flag = last_hdr;
        forever begin
            @(negedge clk);
            if (ifc.in_ready) break;
            t++;
            if (t > 200) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout got=0 exp=1");
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "stream stalled");
            end
        end
        @(posedge clk); #1;
        ifc.in_valid  = 1'b0;
        hdr_last_flag = 1'b0;
    endtask

    task automatic send_all();
        logic [7:0] b;
        bit f;
        while (sb.size() > 0) begin
            b = sb.pop_front();
            f = sf.pop_front();
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            end
            send_byte(b, f);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (hq.size() > 0 || eq.size() > 0 || busy) begin
            @(negedge clk);
            t++;
            if (t > 2000) begin
                checks++; errors++;
                $display("FAIL wait_idle_timeout got=hq%0d/eq%0d exp=0/0", hq.size(), eq.size());
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bq_t p;
        int hs, ss;
        ifc.in_valid   = 1'b0;
        ifc.in_data    = 8'h00;
        ifc.elem_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, ifc.in_ready}, 64'd0);
        chk("rst_hdr_valid", {63'd0, ifc.hdr_valid}, 64'd0);
        chk("rst_elem_valid", {63'd0, ifc.elem_valid}, 64'd0);
        chk("rst_elem_last", {63'd0, ifc.elem_last}, 64'd0);
        chk("rst_err", {63'd0, ifc.err}, 64'd0);
        chk("rst_elem_data", ifc.elem_data, 64'd0);
        chk("rst_hdr_type", ifc.hdr_trnx_type, 64'd0);
        chk("rst_hdr_n", {32'd0, ifc.hdr_n_payloads}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_after_rst", {63'd0, ifc.in_ready}, 64'd1);
        @(posedge clk); #1;

        // DT_INT, two elements
        p = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        add_txn(64'd5, 64'd7, 64'h2, 32'd2, p);
        chk("pin_model_e0", eq[0].d, 64'h1);
        chk("pin_model_e1", eq[1].d, 64'hFFFF_FFFF);
        chk("pin_model_last", {63'd0, eq[1].last}, 64'd1);
        send_all();
        wait_idle();
        chk("t1_last_data", got_data, 64'hFFFF_FFFF);

        // DT_REAL 1.5
        p = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF8, 8'h3F};
        add_txn(64'd1, 64'd2, 64'h3, 32'd1, p);
        send_all();
        wait_idle();
        chk("t2_real_data", got_data, 64'h3FF8_0000_0000_0000);
        chk("t2_real_last", {63'd0, got_last}, 64'd1);

        // n=0 header immediately followed by an unknown data_type transaction
        p = {};
        add_txn(64'd9, 64'd10, 64'h1, 32'd0, p);
        p = '{8'hAA, 8'hBB, 8'hCC};
        add_txn(64'd3, 64'd4, 64'h99, 32'd3, p);
        hs = hdr_seen;
        ss = xfer_count;
        send_all();
        wait_idle();
        chk("t34_hdr_count", 64'(hdr_seen - hs), 64'd2);
        chk("t4_elem_count", 64'(xfer_count - ss), 64'd3);
        chk("t4_last_data", got_data, 64'hCC);

        // DT_BYTE n=4, consumer stall on element 2, random input gaps
        p = '{8'h11, 8'h22, 8'h33, 8'h44};
        add_txn(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h1, 32'd4, p);
        stall_at   = xfer_count + 1;
        stall_left = 10;
        ss         = stall_seen;
        gap_max    = 3;
        send_all();
        wait_idle();
        gap_max = 0;
        chk("t5_stall_cycles", 64'(stall_seen - ss), 64'd10);
        chk("t5_last_data", got_data, 64'h44);

        // reset after 13 header bytes, then a clean DT_INT n=1
        for (int k = 0; k < 13; k++) send_byte(8'(k + 8'h50), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_in_ready", {63'd0, ifc.in_ready}, 64'd0);
        chk("midrst_hdr_type", ifc.hdr_trnx_type, 64'd0);
        chk("midrst_elem_data", ifc.elem_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        hs = hdr_seen;
        p = '{8'h78, 8'h56, 8'h34, 8'h12};
        add_txn(64'd11, 64'd12, 64'h2, 32'd1, p);
        send_all();
        wait_idle();
        chk("t6_hdr_count", 64'(hdr_seen - hs), 64'd1);
        chk("t6_data", got_data, 64'h1234_5678);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
